// File: rtl/dequant_dezigzag.sv
// dequant_dezigzag
//   Dequantizes a stream of JPEG coefficients arriving in zigzag order and
//   re-emits each 8x8 block in raster order for the IDCT. Each coefficient is
//   multiplied by the Annex K quantizer step, saturated to OUT_WIDTH and
//   written into one of two ping-pong banks. A full bank is streamed out in
//   raster order while the other bank fills.
//
// Ports
//   clk, rst        : rising-edge clock, synchronous active-high reset
//   in_valid/ready  : input handshake, in_data is a signed coefficient (zigzag)
//   out_valid/ready : output handshake, out_data is a signed coefficient (raster)
//   out_row_last    : marks column 7 of every row
//   out_block_last  : marks raster index 63
module dequant_dezigzag #(
    parameter int DATA_WIDTH = 10,
    parameter int OUT_WIDTH  = 12,
    parameter int CHANNEL    = 0
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic signed [DATA_WIDTH-1:0] in_data,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic signed [OUT_WIDTH-1:0]  out_data,
    output logic                         out_row_last,
    output logic                         out_block_last
);

    localparam int PROD_W = DATA_WIDTH + 9;

    // Raster position of each zigzag index.
    localparam int ZZ2RASTER [64] = '{
         0,  1,  8, 16,  9,  2,  3, 10, 17, 24, 32, 25, 18, 11,  4,  5,
        12, 19, 26, 33, 40, 48, 41, 34, 27, 20, 13,  6,  7, 14, 21, 28,
        35, 42, 49, 56, 57, 50, 43, 36, 29, 22, 15, 23, 30, 37, 44, 51,
        58, 59, 52, 45, 38, 31, 39, 46, 53, 60, 61, 54, 47, 55, 62, 63};

    // Annex K quantizer tables, stored in raster order.
    localparam int Q_LUMA [64] = '{
        16,  11,  10,  16,  24,  40,  51,  61,
        12,  12,  14,  19,  26,  58,  60,  55,
        14,  13,  16,  24,  40,  57,  69,  56,
        14,  17,  22,  29,  51,  87,  80,  62,
        18,  22,  37,  56,  68, 109, 103,  77,
        24,  35,  55,  64,  81, 104, 113,  92,
        49,  64,  78,  87, 103, 121, 120, 101,
        72,  92,  95,  98, 112, 100, 103,  99};

    localparam int Q_CHROMA [64] = '{
        17, 18, 24, 47, 99, 99, 99, 99,
        18, 21, 26, 66, 99, 99, 99, 99,
        24, 26, 56, 99, 99, 99, 99, 99,
        47, 66, 99, 99, 99, 99, 99, 99,
        99, 99, 99, 99, 99, 99, 99, 99,
        99, 99, 99, 99, 99, 99, 99, 99,
        99, 99, 99, 99, 99, 99, 99, 99,
        99, 99, 99, 99, 99, 99, 99, 99};

    function automatic logic signed [OUT_WIDTH-1:0] sat(input logic signed [PROD_W-1:0] v);
        logic signed [PROD_W-1:0] hi;
        logic signed [PROD_W-1:0] lo;
        hi = PROD_W'({(OUT_WIDTH-1){1'b1}});
        lo = ~hi;
        if (v > hi)
            return {1'b0, {(OUT_WIDTH-1){1'b1}}};
        else if (v < lo)
            return {1'b1, {(OUT_WIDTH-1){1'b0}}};
        else
            return v[OUT_WIDTH-1:0];
    endfunction

    typedef enum logic [1:0] {IDLE, STREAM, HOLD} rd_state_t;

    logic                        in_hs;
    logic [5:0]                  zz_idx;
    logic                        in_bank;
    logic [5:0]                  raster_addr;
    logic [7:0]                  q;
    logic signed [PROD_W-1:0]    a_ext;
    logic signed [PROD_W-1:0]    q_ext;
    logic signed [PROD_W-1:0]    prod;

    logic signed [OUT_WIDTH-1:0] data_p0;
    logic [5:0]                  addr_p0;
    logic                        bank_p0;
    logic                        last_p0;
    logic                        vld_p0;

    logic signed [OUT_WIDTH-1:0] mem [128];
    logic [1:0]                  full;
    logic [1:0]                  full_set;
    logic [1:0]                  full_clr;

    rd_state_t                   rd_state;
    logic                        rd_bank;
    logic [5:0]                  rd_idx;
    logic                        rd_load;
    logic                        rd_done;
    logic                        rd_sel_bank;
    logic [5:0]                  rd_sel_idx;

    // A write bank only becomes free once its reader has finished with it.
    assign in_ready = ~full[in_bank];
    assign in_hs    = in_valid && in_ready;

    assign raster_addr = 6'(ZZ2RASTER[zz_idx]);
    assign q           = (CHANNEL == 0) ? 8'(Q_LUMA[raster_addr]) : 8'(Q_CHROMA[raster_addr]);
    assign a_ext       = PROD_W'(in_data);
    assign q_ext       = PROD_W'({1'b0, q});
    assign prod        = a_ext * q_ext;

    always_ff @(posedge clk) begin
        if (rst) begin
            zz_idx  <= '0;
            in_bank <= 1'b0;
        end else if (in_hs) begin
            zz_idx <= zz_idx + 6'd1;
            if (zz_idx == 6'd63)
                in_bank <= ~in_bank;
        end
    end

    // ---- stage p0: saturated product, raster address and bank registered ----
    always_ff @(posedge clk) begin
        if (in_hs) begin
            data_p0 <= sat(prod);
            addr_p0 <= raster_addr;
            bank_p0 <= in_bank;
            last_p0 <= (zz_idx == 6'd63);
        end
    end

    always_ff @(posedge clk) begin
        if (rst)
            vld_p0 <= 1'b0;
        else
            vld_p0 <= in_hs;
    end

    // ---- stage p1: bank write and full flag update ----
    always_ff @(posedge clk) begin
        if (vld_p0)
            mem[{bank_p0, addr_p0}] <= data_p0;
    end

    // Write completion and read completion always target different banks, so
    // both updates can be applied in the same cycle.
    assign full_set = (vld_p0 && last_p0) ? (2'b01 << bank_p0) : 2'b00;
    assign full_clr = rd_done ? (2'b01 << rd_bank) : 2'b00;

    always_ff @(posedge clk) begin
        if (rst)
            full <= 2'b00;
        else
            full <= (full | full_set) & ~full_clr;
    end

    always_comb begin
        rd_load     = 1'b0;
        rd_done     = 1'b0;
        rd_sel_bank = rd_bank;
        rd_sel_idx  = rd_idx + 6'd1;
        case (rd_state)
            IDLE: begin
                if (full[rd_bank]) begin
                    rd_load    = 1'b1;
                    rd_sel_idx = 6'd0;
                end
            end
            default: begin
                if (out_ready) begin
                    if (rd_idx == 6'd63) begin
                        // Chain straight into the other bank when it is waiting.
                        rd_done     = 1'b1;
                        rd_sel_bank = ~rd_bank;
                        rd_sel_idx  = 6'd0;
                        rd_load     = full[~rd_bank];
                    end else begin
                        rd_load = 1'b1;
                    end
                end
            end
        endcase
    end

    // ---- stage p2: registered raster-order output ----
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_state       <= IDLE;
            rd_bank        <= 1'b0;
            rd_idx         <= '0;
            out_valid      <= 1'b0;
            out_data       <= '0;
            out_row_last   <= 1'b0;
            out_block_last <= 1'b0;
        end else begin
            if (rd_done)
                rd_bank <= ~rd_bank;
            if (rd_load) begin
                rd_state       <= STREAM;
                rd_idx         <= rd_sel_idx;
                out_valid      <= 1'b1;
                out_data       <= mem[{rd_sel_bank, rd_sel_idx}];
                out_row_last   <= &rd_sel_idx[2:0];
                out_block_last <= &rd_sel_idx;
            end else if (rd_done) begin
                rd_state       <= IDLE;
                out_valid      <= 1'b0;
                out_row_last   <= 1'b0;
                out_block_last <= 1'b0;
            end else if (rd_state != IDLE && !out_ready) begin
                rd_state <= HOLD;
            end
        end
    end

endmodule

// File: tb/tb_dequant_dezigzag.sv
module tb_dequant_dezigzag;

    logic              clk = 1'b0;
    logic              rst;
    logic              in_valid;
    logic              out_ready;
    logic signed [9:0] in_data;

    logic               in_ready0, out_valid0, row_last0, block_last0;
    logic signed [11:0] out_data0;
    logic               in_ready1, out_valid1, row_last1, block_last1;
    logic signed [11:0] out_data1;

    always #5 clk = ~clk;

    dequant_dezigzag #(.DATA_WIDTH(10), .OUT_WIDTH(12), .CHANNEL(0)) dut0 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready0), .in_data(in_data),
        .out_valid(out_valid0), .out_ready(out_ready), .out_data(out_data0),
        .out_row_last(row_last0), .out_block_last(block_last0));

    dequant_dezigzag #(.DATA_WIDTH(10), .OUT_WIDTH(12), .CHANNEL(1)) dut1 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready1), .in_data(in_data),
        .out_valid(out_valid1), .out_ready(out_ready), .out_data(out_data1),
        .out_row_last(row_last1), .out_block_last(block_last1));

    int QL [64] = '{
        16,  11,  10,  16,  24,  40,  51,  61,
        12,  12,  14,  19,  26,  58,  60,  55,
        14,  13,  16,  24,  40,  57,  69,  56,
        14,  17,  22,  29,  51,  87,  80,  62,
        18,  22,  37,  56,  68, 109, 103,  77,
        24,  35,  55,  64,  81, 104, 113,  92,
        49,  64,  78,  87, 103, 121, 120, 101,
        72,  92,  95,  98, 112, 100, 103,  99};
    int QC [64];
    int ROW0 [8] = '{16, 11, 10, 16, 24, 40, 51, 61};

    int zz [64];
    int blk [64];
    int exp_l [$];
    int exp_c [$];
    int got_l [64];
    int got_c [64];
    int kin, oidx;
    int n_assert, n_fail;
    int n_out, n_rowlast, blocks_in, blocks_out;

    function automatic int sat12(input int v);
        if (v > 2047) return 2047;
        if (v < -2048) return -2048;
        return v;
    endfunction

    task automatic chk(input string tag, input logic signed [31:0] obs, input int expv);
        n_assert++;
        assert (obs === expv)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0d, expected %0d", tag, obs, expv);
        end
    endtask

    // Reference: collect 64 zigzag inputs, then emit the dequantized block in raster order.
    task automatic model_in(input int x);
        int tl [64];
        int tc [64];
        blk[kin] = x;
        kin++;
        if (kin == 64) begin
            for (int k = 0; k < 64; k++) begin
                tl[zz[k]] = sat12(blk[k] * QL[zz[k]]);
                tc[zz[k]] = sat12(blk[k] * QC[zz[k]]);
            end
            for (int r = 0; r < 64; r++) begin
                exp_l.push_back(tl[r]);
                exp_c.push_back(tc[r]);
            end
            kin = 0;
            blocks_in++;
        end
    endtask

    task automatic check_out();
        int el, ec;
        if (exp_l.size() == 0) begin
            chk("unexpected_output", exp_l.size(), 1);
            return;
        end
        el = exp_l.pop_front();
        ec = exp_c.pop_front();
        chk("data_luma", out_data0, el);
        chk("data_chroma", out_data1, ec);
        chk("row_last", row_last0, int'(oidx % 8 == 7));
        chk("block_last", block_last0, int'(oidx == 63));
        got_l[oidx] = out_data0;
        got_c[oidx] = out_data1;
        if (row_last0) n_rowlast++;
        n_out++;
        oidx = (oidx + 1) % 64;
        if (oidx == 0) blocks_out++;
    endtask

    // One clock: record handshakes seen before the edge, then advance.
    task automatic cycle();
        bit ihs, ohs;
        ihs = in_valid && in_ready0;
        ohs = out_valid0 && out_ready;
        if (ohs) check_out();
        if (ihs) model_in(int'(in_data));
        @(posedge clk);
        #1;
    endtask

    task automatic feed_one(input int v);
        int n;
        bit h;
        in_valid = 1'b1;
        in_data  = 10'(v);
        n = 0;
        h = 1'b0;
        while (!h && n < 1000) begin
            h = in_ready0;
            cycle();
            n++;
        end
        if (!h) chk("feed_timeout", in_ready0, 1);
        in_valid = 1'b0;
    endtask

    task automatic drain(input int budget);
        int n;
        out_ready = 1'b1;
        in_valid  = 1'b0;
        n = 0;
        while ((exp_l.size() != 0 || out_valid0) && n < budget) begin
            cycle();
            n++;
        end
        chk("drain_complete", exp_l.size(), 0);
    endtask

    function automatic int rnd10();
        return int'($urandom_range(0, 1023)) - 512;
    endfunction

    initial begin
        int idx, acc, cnt, base, target, n;
        n_assert = 0; n_fail = 0; n_out = 0; n_rowlast = 0;
        blocks_in = 0; blocks_out = 0; kin = 0; oidx = 0;

        for (int r = 0; r < 64; r++) QC[r] = 99;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++) QC[r*8+c] = 0;
        QC[0] = 17; QC[1] = 18; QC[2] = 24; QC[3] = 47;
        QC[8] = 18; QC[9] = 21; QC[10] = 26; QC[11] = 66;
        QC[16] = 24; QC[17] = 26; QC[18] = 56; QC[19] = 99;
        QC[24] = 47; QC[25] = 66; QC[26] = 99; QC[27] = 99;

        // Zigzag order: walk anti-diagonals, alternating direction.
        idx = 0;
        for (int s = 0; s < 15; s++) begin
            int rlo, rhi;
            rlo = (s > 7) ? s - 7 : 0;
            rhi = (s < 7) ? s : 7;
            if (s % 2 == 0)
                for (int r = rhi; r >= rlo; r--) begin zz[idx] = r*8 + (s - r); idx++; end
            else
                for (int r = rlo; r <= rhi; r++) begin zz[idx] = r*8 + (s - r); idx++; end
        end

        // Reset state
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; in_data = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", out_valid0, 0);
        chk("rst_in_ready", in_ready0, 1);
        chk("rst_out_data", out_data0, 0);
        chk("rst_row_last", row_last0, 0);
        chk("rst_block_last", block_last0, 0);
        rst = 1'b0;
        cycle();

        // All +1, luma row 0 and fixed latency
        out_ready = 1'b1;
        for (int k = 0; k < 63; k++) feed_one(1);
        feed_one(1);
        chk("lat_after_T", out_valid0, 0);
        cycle();
        chk("lat_T+1", out_valid0, 0);
        cycle();
        chk("lat_T+2", out_valid0, 1);
        drain(300);
        for (int c = 0; c < 8; c++) chk("ones_row0", got_l[c], ROW0[c]);
        chk("ones_last", got_l[63], 99);

        // Single +1 at zigzag index 2
        base = n_rowlast;
        for (int k = 0; k < 64; k++) feed_one(k == 2 ? 1 : 0);
        drain(300);
        chk("zz2_raster8", got_l[8], 12);
        chk("zz2_raster0", got_l[0], 0);
        chk("zz2_raster2", got_l[2], 0);
        chk("zz2_rowlast_count", n_rowlast - base, 8);

        // Saturation
        for (int k = 0; k < 64; k++) feed_one(k == 0 ? -512 : 0);
        drain(300);
        chk("sat_chroma_neg", got_c[0], -2048);
        for (int k = 0; k < 64; k++) feed_one(k == 0 ? 200 : 0);
        drain(300);
        chk("sat_luma_pos", got_l[0], 2047);

        // Backpressure: both banks fill, then drain without gaps
        out_ready = 1'b0;
        in_valid  = 1'b1;
        acc = 0;
        repeat (140) begin
            in_data = 10'(rnd10());
            if (in_ready0) acc++;
            cycle();
        end
        in_valid = 1'b0;
        chk("bp_accepted", acc, 128);
        chk("bp_in_ready", in_ready0, 0);
        chk("bp_holding", out_valid0, 1);
        out_ready = 1'b1;
        repeat (63) cycle();
        chk("bp_ready_before_swap", in_ready0, 0);
        cycle();
        chk("bp_ready_at_swap", in_ready0, 1);
        chk("bp_valid_at_swap", out_valid0, 1);
        cnt = 0;
        repeat (64) begin
            if (out_valid0) cnt++;
            cycle();
        end
        chk("bp_no_gaps", cnt, 64);
        chk("bp_idle_after", out_valid0, 0);
        chk("bp_model_empty", exp_l.size(), 0);

        // Reset mid-operation
        out_ready = 1'b0;
        for (int k = 0; k < 64; k++) feed_one(rnd10());
        repeat (3) cycle();
        for (int k = 0; k < 30; k++) feed_one(rnd10());
        rst = 1'b1; in_valid = 1'b0;
        @(posedge clk);
        #1;
        chk("mid_rst_out_valid", out_valid0, 0);
        chk("mid_rst_in_ready", in_ready0, 1);
        rst = 1'b0;
        exp_l.delete(); exp_c.delete();
        kin = 0; oidx = 0;
        base = n_out;
        out_ready = 1'b1;
        for (int k = 0; k < 64; k++) feed_one(rnd10());
        drain(300);
        repeat (80) cycle();
        chk("mid_rst_fresh_only", n_out - base, 64);

        // Random handshakes over 20 blocks
        target = blocks_in + 20;
        base = blocks_out;
        n = 0;
        while (blocks_in < target && n < 20000) begin
            in_valid  = ($urandom % 4) != 0;
            in_data   = 10'(rnd10());
            out_ready = ($urandom % 3) != 0;
            cycle();
            n++;
        end
        in_valid = 1'b0;
        chk("rand_blocks_in", blocks_in, target);
        drain(2000);
        chk("rand_blocks_out", blocks_out - base, 20);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/dequant_dezigzag.md
DEQUANT_DEZIGZAG -- requirements
Module: dequant_dezigzag

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 10: signed width of quantized input coefficients.
REQ-002 SHALL have parameter OUT_WIDTH, default 12: signed width of dequantized output coefficients.
REQ-003 SHALL have parameter CHANNEL, default 0: 0 selects the JPEG Annex K luma table; any other value selects the chroma table.
REQ-004 SHALL have port clk, input, 1: single clock; all logic on its rising edge.
REQ-005 SHALL have port rst, input, 1: synchronous, active-high reset.
REQ-006 SHALL have port in_valid, input, 1: input coefficient valid.
REQ-007 SHALL have port in_ready, output, 1: block can accept an input coefficient.
REQ-008 SHALL have port in_data, input, DATA_WIDTH: signed quantized coefficient, zigzag order.
REQ-009 SHALL have port out_valid, output, 1: output coefficient valid.
REQ-010 SHALL have port out_ready, input, 1: downstream (IDCT) accepts output.
REQ-011 SHALL have port out_data, output, OUT_WIDTH: signed dequantized coefficient, raster order.
REQ-012 SHALL have port out_row_last, output, 1: high on column 7 of each row.
REQ-013 SHALL have port out_block_last, output, 1: high on raster index 63.

Function
REQ-014 SHALL treat an input handshake as in_valid && in_ready, and an output handshake as out_valid && out_ready.
REQ-015 SHALL count input handshakes 0..63 as zigzag index k, and wrap to 0 after 63.
REQ-016 SHALL compute in_data * Q[k], where Q is 8-bit unsigned and indexed in zigzag order.
REQ-017 SHALL saturate the product to [-2^(OUT_WIDTH-1), 2^(OUT_WIDTH-1)-1].
REQ-018 SHALL register the saturated product for one cycle before writing it to raster address zz2raster(k) of the current write bank.
REQ-019 SHALL provide two 64-entry banks (ping-pong), each with a full flag.
  - Write bank toggles after the 64th write.
  - Read bank toggles after the output handshake on raster index 63.
REQ-020 SHALL drive in_ready = 0 while the current write bank is full.
REQ-021 SHALL drive in_ready = 1 otherwise, including while the read side drains the other bank.
REQ-022 SHALL read the full bank in raster order 0..63.
  - Output path is registered.
  - out_valid stays high across the block while out_ready is high, with no bubbles.
REQ-023 SHALL hold out_data, out_row_last and out_block_last stable while out_valid && !out_ready.
REQ-024 SHALL give fixed latency when the read side is idle: 64th input handshake at cycle T, then out_valid for raster index 0 rises at T+3.
REQ-025 SHALL apply both flag updates when the 64th write and a read-side block completion occur in the same cycle.
  - Set on the write bank, clear on the read bank.
  - Neither update is lost.
REQ-026 SHALL on a read-side block completion with the other bank already full:
  - present index 0 of that bank on the next cycle, with no idle cycle;
  - and in_ready rises on the same cycle as that presentation.
REQ-027 SHALL use a read FSM with states IDLE, STREAM and HOLD.
  - IDLE -> STREAM when the read bank becomes full.
  - STREAM -> HOLD when out_ready = 0.
  - HOLD -> STREAM when out_ready = 1.
  - STREAM -> IDLE after index 63 if the other bank is not full.
REQ-028 SHALL set out_row_last = 1 exactly when raster index mod 8 = 7.
REQ-029 SHALL set out_block_last = 1 exactly when raster index = 63.

Reset
REQ-030 SHALL on rst, at the next edge, drive out_valid = 0, out_row_last = 0, out_block_last = 0, out_data = 0 and in_ready = 1.
REQ-031 SHALL on rst clear both full flags, set zigzag and raster counters to 0, set both bank pointers to bank 0, and enter FSM state IDLE.
REQ-032 SHALL discard any partially written or partially read block when rst is asserted mid-operation.
  - Bank contents need not be cleared.
  - No stale block may be emitted after reset.

Verification
REQ-033 SHALL cover: CHANNEL=0, 64 inputs of +1, out_ready=1 -> row 0 out = 16 11 10 16 24 40 51 61; last out = 99; out_valid rises T+3.
REQ-034 SHALL cover: CHANNEL=0, single +1 at zigzag index 2, rest 0 -> raster index 8 = 12, others 0; out_row_last on indices 7,15,...,63.
REQ-035 SHALL cover: CHANNEL=1, DC = -512, rest 0 -> product -8704 saturates to -2048 at index 0; CHANNEL=0, DC = +200 -> 3200 saturates to 2047.
REQ-036 SHALL cover: out_ready=0 throughout, continuous in_valid -> 128 inputs accepted, in_ready=0 from the 129th; raising out_ready drains both blocks (128 outputs) with no gaps.
REQ-037 SHALL cover: random in_valid/out_ready toggling over 20 blocks -> output matches reference model; each 64th write coinciding with a read completion loses no block.
REQ-038 SHALL cover: rst asserted after 30 inputs -> next edge out_valid=0, in_ready=1; a following fresh 64-input block emits only its own data.
